// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t : FSM encoding {IDLE, BUSY, DONE}
//   cnt_w   : width of the step counter, able to hold WIDTH
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One iteration of the shift-add multiplier.
// The add/subtract is conditional on acc[0]. The result is then shifted right by one.
//   acc      in  2*WIDTH+1  accumulator: upper WIDTH+1 bits hold the partial sum,
//                           the lower WIDTH bits hold the remaining multiplier bits
//   mcand    in  WIDTH      multiplicand
//   sub      in  1          subtract mcand instead of adding it (signed sign-bit step)
//   arith    in  1          two's-complement operands: sign-extend mcand, arithmetic shift
//   acc_next out 2*WIDTH+1  accumulator after the step
module mult_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic             sub,
  input  logic             arith,
  output logic [2*WIDTH:0] acc_next
);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] upper;
  logic [WIDTH:0] sum;

  always_comb begin
    ext   = {arith & mcand[WIDTH-1], mcand};
    upper = acc[2*WIDTH:WIDTH];
    sum   = upper;
    if (acc[0]) begin
      sum = sub ? (upper - ext) : (upper + ext);
    end
    // The upper part is WIDTH+1 bits wide, so the carry survives the shift.
    acc_next = {arith & sum[WIDTH], sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier. It performs one add/shift step per clock, and a product takes WIDTH steps.
// Operands are accepted with a valid/ready handshake and held in registers.
// The product is presented with a valid/ready handshake and held until the consumer takes it.
// Optional signed mode is enabled by the MULT_SIGNED_EN macro.
//   clk          in   1        clock, posedge
//   rst          in   1        synchronous active-high reset
//   in_valid     in   1        operands valid
//   in_ready     out  1        ready for operands (IDLE)
//   a            in   WIDTH    multiplicand
//   b            in   WIDTH    multiplier
//   signed_mode  in   1        only with MULT_SIGNED_EN; 1 = two's-complement operands
//   out_valid    out  1        product valid (DONE)
//   out_ready    in   1        consumer accepts product
//   product      out  2*WIDTH  registered product
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MULT_SIGNED_EN
  input  logic                 signed_mode,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        count_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH:0]     acc_q;
  logic [2*WIDTH:0]     acc_next;
  logic [2*WIDTH-1:0]   product_q;
  logic                 sgn;
  logic                 last_step;

`ifdef MULT_SIGNED_EN
  logic sgn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      sgn_q <= signed_mode;
    end
  end

  assign sgn = sgn_q;
`else
  assign sgn = 1'b0;
`endif

  assign last_step = (count_q == CNT_LAST);

  // The multiplier sign bit carries negative weight, so it is subtracted on the final step.
  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .mcand    (mcand_q),
    .sub      (sgn & last_step),
    .arith    (sgn),
    .acc_next (acc_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q <= a;
            acc_q   <= {{(WIDTH + 1){1'b0}}, b};
            count_q <= CNT_INIT;
          end
        end
        BUSY: begin
          acc_q   <= acc_next;
          count_q <= count_q - CNT_LAST;
          if (last_step) begin
            product_q <= acc_next[2*WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sm;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
`ifdef MULT_SIGNED_EN
    .signed_mode (sm),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product)
  );

  always #5 clk = ~clk;

  // Present operands for one accept edge.
  // Then count edges, including the accept edge, until out_valid rises (bounded).
  task automatic start_and_wait(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vs, output int edges);
    @(negedge clk);
    a = va; b = vb; sm = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b product=%0d, required 1 0 0",
               in_ready, out_valid, product);
    end
  endtask

  task automatic test_basic();
    int e;
    out_ready = 1'b1;
    start_and_wait(4'd7, 4'd7, 1'b0, e);
    n_checks++;
    if (e != 5) begin
      n_fail++;
      $display("FAIL latency_7x7: edges=%0d required 5", e);
    end
    n_checks++;
    if (product !== 8'd49) begin
      n_fail++;
      $display("FAIL product_7x7: got %0d required 49", product);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 8'd49) begin
      n_fail++;
      $display("FAIL idle_after_7x7: in_ready=%b out_valid=%b product=%0d required 1 0 49",
               in_ready, out_valid, product);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta [4] = '{4'd15, 4'd0, 4'd1,  4'd15};
    logic [W-1:0]   tb [4] = '{4'd15, 4'd9, 4'd15, 4'd1};
    logic [2*W-1:0] tp [4] = '{8'd225, 8'd0, 8'd15, 8'd15};
    int e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_and_wait(ta[i], tb[i], 1'b0, e);
      n_checks++;
      if (e != 5 || product !== tp[i]) begin
        n_fail++;
        $display("FAIL corner_%0d: %0d*%0d got %0d after %0d edges, required %0d after 5",
                 i, ta[i], tb[i], product, e, tp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int e;
    int bad = 0;
    out_ready = 1'b0;
    start_and_wait(4'd3, 4'd5, 1'b0, e);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (product !== 8'd15 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || e != 5) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d bad cycles, product=%0d out_valid=%b in_ready=%b, required 15 1 0",
               bad, product, out_valid, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b required 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_busy_ignore();
    int e;
    out_ready = 1'b1;
    @(negedge clk);
    a = 4'd6; b = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    // Operands change and in_valid stays high while BUSY.
    a = 4'd2; b = 4'd2;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_in_ready: got %b required 0", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = 2;
    while (out_valid !== 1'b1 && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    n_checks++;
    if (e != 5 || product !== 8'd30) begin
      n_fail++;
      $display("FAIL busy_ignore: got %0d after %0d edges, required 30 after 5", product, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int e;
    out_ready = 1'b1;
    @(negedge clk);
    a = 4'd5; b = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_midop: in_ready=%b out_valid=%b product=%0d required 1 0 0",
               in_ready, out_valid, product);
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || product !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_discard: out_valid=%b product=%0d required 0 0", out_valid, product);
    end
    start_and_wait(4'd3, 4'd3, 1'b0, e);
    n_checks++;
    if (e != 5 || product !== 8'd9) begin
      n_fail++;
      $display("FAIL after_reset_3x3: got %0d after %0d edges, required 9 after 5", product, e);
    end
    @(posedge clk); #1;
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0]   ta [4] = '{4'h8,  4'hF,  4'hF,  4'h7};
    logic [W-1:0]   tb [4] = '{4'h7,  4'hF,  4'hF,  4'h8};
    logic           ts [4] = '{1'b1,  1'b1,  1'b0,  1'b1};
    logic [2*W-1:0] tp [4] = '{8'hC8, 8'h01, 8'hE1, 8'hC8};
    int e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_and_wait(ta[i], tb[i], ts[i], e);
      n_checks++;
      if (e != 5 || product !== tp[i]) begin
        n_fail++;
        $display("FAIL signed_%0d: got %h after %0d edges, required %h after 5",
                 i, product, e, tp[i]);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_busy_ignore();
    test_reset_midop();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
